// File: rtl/cache_pkg.sv
// cache_pkg: geometry, FSM states and address
// helpers shared by the direct-mapped data cache.
package cache_pkg;

  localparam int ADDR_WIDTH     = 16;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_LINES      = 64;
  localparam int WORDS_PER_LINE = 4;

  localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - WORD_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[ADDR_WIDTH-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_index(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[OFF_W+WORD_W +: IDX_W];
  endfunction

  function automatic logic [WORD_W-1:0] get_word(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[OFF_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: tag/valid/dirty/data arrays,
// synchronous write, combinational read of one line.
module cache_line_store
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  wr_en,
  input  logic [WORD_W-1:0]     wr_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fill_done,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic                  set_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] rd_line
);

  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  // data and tag arrays: plain write ports, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) data_q[idx][wr_word] <= wr_data;
    if (fill_done) tag_q[idx] <= fill_tag;
  end

  // line state flags: cleared by reset, set by refill/write
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (set_dirty) dirty_q[idx] <= 1'b1;
    end
  end

  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_line  = data_q[idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-back, write-allocate
// data cache controller with word-wide memory port.
module dm_cache_ctrl
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_hit,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam logic [WORD_W-1:0] LAST =
    WORD_W'(WORDS_PER_LINE - 1);

  state_t state, state_n;

  logic [TAG_W-1:0]      req_tag, req_tag_n;
  logic [IDX_W-1:0]      req_idx, req_idx_n;
  logic [WORD_W-1:0]     req_word, req_word_n;
  logic [DATA_WIDTH-1:0] req_wdata, req_wdata_n;
  logic                  req_wr, req_wr_n;
  logic [WORD_W-1:0]     cnt, cnt_n, cnt_inc;

  logic [DATA_WIDTH-1:0] rdata_n, mwdata_n;
  logic [ADDR_WIDTH-1:0] maddr_n;
  logic                  ready_n, hit_n, mrd_n, mwr_n;

  logic [TAG_W-1:0]      line_tag;
  logic                  line_valid, line_dirty;
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_data;

  logic                  wr_en, fill_done, set_dirty;
  logic [WORD_W-1:0]     wr_word;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  hit;
  logic                  unused_off;

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [TAG_W-1:0]  t,
    input logic [IDX_W-1:0]  i,
    input logic [WORD_W-1:0] w
  );
    return {t, i, w, {OFF_W{1'b0}}};
  endfunction

  assign unused_off = ^cpu_addr[OFF_W-1:0];
  assign hit        = line_valid && (line_tag == req_tag);
  assign cnt_inc    = cnt + 1'b1;

  cache_line_store u_store (
    .clk       (clk),
    .rst       (rst),
    .idx       (req_idx),
    .wr_en     (wr_en),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .fill_done (fill_done),
    .fill_tag  (req_tag),
    .set_dirty (set_dirty),
    .rd_tag    (line_tag),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_line   (line_data)
  );

  // next state, registered-output values and array writes
  always_comb begin
    state_n     = state;
    req_tag_n   = req_tag;
    req_idx_n   = req_idx;
    req_word_n  = req_word;
    req_wdata_n = req_wdata;
    req_wr_n    = req_wr;
    cnt_n       = cnt;
    rdata_n     = cpu_rdata;
    ready_n     = 1'b0;
    hit_n       = 1'b0;
    mrd_n       = mem_read;
    mwr_n       = mem_write;
    maddr_n     = mem_addr;
    mwdata_n    = mem_wdata;
    wr_en       = 1'b0;
    wr_word     = req_word;
    wr_data     = req_wdata;
    fill_done   = 1'b0;
    set_dirty   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          req_tag_n   = get_tag(cpu_addr);
          req_idx_n   = get_index(cpu_addr);
          req_word_n  = get_word(cpu_addr);
          req_wdata_n = cpu_wdata;
          req_wr_n    = cpu_write;
          state_n     = LOOKUP;
        end
      end
      LOOKUP: begin
        cnt_n = '0;
        if (hit) begin
          ready_n = 1'b1;
          hit_n   = 1'b1;
          state_n = IDLE;
          if (req_wr) begin
            wr_en     = 1'b1;
            set_dirty = 1'b1;
            rdata_n   = req_wdata;
          end else begin
            rdata_n = line_data[req_word];
          end
        end else if (line_valid && line_dirty) begin
          state_n  = WRITEBACK;
          mwr_n    = 1'b1;
          maddr_n  = beat_addr(line_tag, req_idx, '0);
          mwdata_n = line_data[0];
        end else begin
          state_n = REFILL;
          mrd_n   = 1'b1;
          maddr_n = beat_addr(req_tag, req_idx, '0);
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          if (cnt == LAST) begin
            mwr_n   = 1'b0;
            mrd_n   = 1'b1;
            cnt_n   = '0;
            state_n = REFILL;
            maddr_n = beat_addr(req_tag, req_idx, '0);
          end else begin
            cnt_n    = cnt_inc;
            maddr_n  = beat_addr(line_tag, req_idx, cnt_inc);
            mwdata_n = line_data[cnt_inc];
          end
        end
      end
      REFILL: begin
        if (mem_ready) begin
          wr_en   = 1'b1;
          wr_word = cnt;
          wr_data = mem_rdata;
          if (cnt == LAST) begin
            mrd_n     = 1'b0;
            fill_done = 1'b1;
            cnt_n     = '0;
            state_n   = RESPOND;
          end else begin
            cnt_n   = cnt_inc;
            maddr_n = beat_addr(req_tag, req_idx, cnt_inc);
          end
        end
      end
      RESPOND: begin
        ready_n = 1'b1;
        state_n = IDLE;
        if (req_wr) begin
          wr_en     = 1'b1;
          set_dirty = 1'b1;
          rdata_n   = req_wdata;
        end else begin
          rdata_n = line_data[req_word];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      req_tag   <= '0;
      req_idx   <= '0;
      req_word  <= '0;
      req_wdata <= '0;
      req_wr    <= 1'b0;
      cnt       <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      req_tag   <= req_tag_n;
      req_idx   <= req_idx_n;
      req_word  <= req_word_n;
      req_wdata <= req_wdata_n;
      req_wr    <= req_wr_n;
      cnt       <= cnt_n;
      cpu_rdata <= rdata_n;
      cpu_ready <= ready_n;
      cpu_hit   <= hit_n;
      mem_read  <= mrd_n;
      mem_write <= mwr_n;
      mem_addr  <= maddr_n;
      mem_wdata <= mwdata_n;
    end
  end

endmodule
